// File: rtl/pred_pkg.sv
// pred_pkg -- shared types and constants for the intra-prediction scheduler.
//   state_t      : scheduler FSM states (IDLE / RUN / FIN)
//   PU_*         : prediction-unit size codes (4..7 all mean 64x64)
//   WEIGHT_SUM   : angular weights always sum to this value
//   IDX_W        : width of the signed reference-array indices
//   ACC_W        : width of the signed angular row accumulator
//   nt_m1_of()   : (block side - 1) for a size code, clamped at 64x64
package pred_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [2:0] PU_4X4   = 3'd0;
    localparam logic [2:0] PU_8X8   = 3'd1;
    localparam logic [2:0] PU_16X16 = 3'd2;
    localparam logic [2:0] PU_32X32 = 3'd3;
    localparam logic [2:0] PU_64X64 = 3'd4;

    localparam int WEIGHT_SUM = 32;
    localparam int IDX_W      = 8;
    // 64 rows * |angle| <= 2048 needs 12 magnitude bits plus sign.
    localparam int ACC_W      = 13;

    function automatic logic [5:0] nt_m1_of(input logic [2:0] pu);
        if (pu >= PU_64X64) return 6'd63;
        return 6'((6'd4 << pu) - 6'd1);
    endfunction

endpackage

// File: rtl/pred_xy_cnt.sv
// pred_xy_cnt -- raster (x fastest) coordinate counter for one PU.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : restart at (0,0)
//   adv        : step to the next sample
//   nt_m1      : block side minus one
//   x, y       : coordinates of the sample currently presented
//   x_nxt,y_nxt: coordinates after this cycle's clr/adv
//   row_end    : x is at the last column
//   last       : current sample is the final one of the PU
module pred_xy_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    input  logic [5:0] nt_m1,
    output logic [5:0] x,
    output logic [5:0] y,
    output logic [5:0] x_nxt,
    output logic [5:0] y_nxt,
    output logic       row_end,
    output logic       last
);

    always_comb begin
        row_end = (x == nt_m1);
        last    = row_end && (y == nt_m1);
        x_nxt   = x;
        y_nxt   = y;
        if (clr) begin
            x_nxt = 6'd0;
            y_nxt = 6'd0;
        end else if (adv) begin
            if (row_end) begin
                x_nxt = 6'd0;
                y_nxt = y + 6'd1;
            end else begin
                x_nxt = x + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= 6'd0;
            y <= 6'd0;
        end else begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

endmodule

// File: rtl/pred_sched.sv
// pred_sched -- control-word scheduler for HEVC-style intra prediction.
// Emits one registered control word per sample of a PU in raster order,
// with a valid/ready handshake towards the prediction datapath.
//   clk, rst        : clock, asynchronous active-high reset
//   START           : begin a PU (accepted only when idle)
//   PU, MODE, ANGLE : size code, 1=angular/0=planar, signed angle
//   TRANSPOSE       : swap emitted X/Y (only with PRED_SCHED_TRANSPOSE_EN)
//   OUT_READY       : downstream accepts the presented word
//   BUSY, DONE      : PU in progress / one-cycle end pulse
//   OUT_VALID       : control word valid
//   PU_O, ANGLE_OR_PLANAR, WEIGHT1/2, REF1/2/1A/2A_IDX, X, Y : control word
// Optional feature macro: PRED_SCHED_TRANSPOSE_EN.
module pred_sched
    import pred_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              START,
    input  logic [2:0]        PU,
    input  logic              MODE,
    input  logic signed [5:0] ANGLE,
`ifdef PRED_SCHED_TRANSPOSE_EN
    input  logic              TRANSPOSE,
`endif
    input  logic              OUT_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              OUT_VALID,
    output logic [2:0]        PU_O,
    output logic              ANGLE_OR_PLANAR,
    output logic [7:0]        WEIGHT1,
    output logic [7:0]        WEIGHT2,
    output logic signed [IDX_W-1:0] REF1_IDX,
    output logic signed [IDX_W-1:0] REF2_IDX,
    output logic signed [IDX_W-1:0] REF1A_IDX,
    output logic signed [IDX_W-1:0] REF2A_IDX,
    output logic [5:0]        X,
    output logic [5:0]        Y
);

    state_t state, state_nxt;

    logic       vld_p1;
    logic [2:0] pu_p1;
    logic       mode_p1;
    logic signed [5:0]       ang_p1;
    logic signed [ACC_W-1:0] acc_p1, acc_nxt;

    logic [5:0] cx, cy, x_nxt, y_nxt;
    logic       row_end, last;

    logic start_acc, accept, adv, fin_acc;

    assign start_acc = (state == ST_IDLE) && START;
    assign accept    = vld_p1 && OUT_READY;
    assign adv       = accept && !last;
    assign fin_acc   = accept && last;

    pred_xy_cnt u_xy (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_acc),
        .adv    (adv),
        .nt_m1  (nt_m1_of(pu_p1)),
        .x      (cx),
        .y      (cy),
        .x_nxt  (x_nxt),
        .y_nxt  (y_nxt),
        .row_end(row_end),
        .last   (last)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (START)   state_nxt = ST_RUN;
            ST_RUN:  if (fin_acc) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs (decoded straight from the state register)
    always_comb begin
        BUSY = (state == ST_RUN);
        DONE = (state == ST_FIN);
    end

    // Stage p0: next control word, computed from the coordinates and
    // accumulator that will be presented after this edge. On START the
    // parameters come straight from the inputs since nothing is latched yet.
    logic        mode_sel, swap_sel;
    logic [7:0]  nt_sel;
    logic [4:0]  fact;
    logic [7:0]  iidx, w1_p0, w2_p0;
    logic signed [IDX_W-1:0] r1_p0, r2_p0, r1a_p0, r2a_p0;
    logic [5:0]  x_p0, y_p0;

`ifdef PRED_SCHED_TRANSPOSE_EN
    logic trans_p1;
    assign swap_sel = start_acc ? TRANSPOSE : trans_p1;
`else
    assign swap_sel = 1'b0;
`endif

    // Row accumulator: (y+1)*ANGLE built by repeated addition.
    always_comb begin
        acc_nxt = acc_p1;
        if (start_acc)
            acc_nxt = ACC_W'(ANGLE);
        else if (adv && row_end)
            acc_nxt = acc_p1 + ACC_W'(ang_p1);
    end

    always_comb begin
        mode_sel = start_acc ? MODE : mode_p1;
        nt_sel   = {2'b00, nt_m1_of(start_acc ? PU : pu_p1)} + 8'd1;
        fact     = acc_nxt[4:0];
        iidx     = {2'b00, x_nxt} + 8'(acc_nxt >>> 5) + 8'd1;
        if (mode_sel) begin
            w1_p0  = 8'(WEIGHT_SUM) - {3'b000, fact};
            w2_p0  = {3'b000, fact};
            r1_p0  = iidx;
            r2_p0  = iidx + 8'd1;
            r1a_p0 = '0;
            r2a_p0 = '0;
        end else begin
            w1_p0  = nt_sel - 8'd1 - {2'b00, x_nxt};
            w2_p0  = nt_sel - 8'd1 - {2'b00, y_nxt};
            r1_p0  = {2'b00, y_nxt};
            r2_p0  = {2'b00, x_nxt};
            r1a_p0 = nt_sel;
            r2a_p0 = nt_sel;
        end
        x_p0 = swap_sel ? y_nxt : x_nxt;
        y_p0 = swap_sel ? x_nxt : y_nxt;
    end

    // Stage p1: registered control word and latched PU parameters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            pu_p1     <= '0;
            mode_p1   <= 1'b0;
            ang_p1    <= '0;
            acc_p1    <= '0;
            WEIGHT1   <= '0;
            WEIGHT2   <= '0;
            REF1_IDX  <= '0;
            REF2_IDX  <= '0;
            REF1A_IDX <= '0;
            REF2A_IDX <= '0;
            X         <= '0;
            Y         <= '0;
`ifdef PRED_SCHED_TRANSPOSE_EN
            trans_p1  <= 1'b0;
`endif
        end else begin
            acc_p1 <= acc_nxt;
            if (start_acc) begin
                vld_p1   <= 1'b1;
                pu_p1    <= PU;
                mode_p1  <= MODE;
                ang_p1   <= ANGLE;
`ifdef PRED_SCHED_TRANSPOSE_EN
                trans_p1 <= TRANSPOSE;
`endif
            end else if (fin_acc) begin
                vld_p1 <= 1'b0;
            end
            if (start_acc || adv) begin
                WEIGHT1   <= w1_p0;
                WEIGHT2   <= w2_p0;
                REF1_IDX  <= r1_p0;
                REF2_IDX  <= r2_p0;
                REF1A_IDX <= r1a_p0;
                REF2A_IDX <= r2a_p0;
                X         <= x_p0;
                Y         <= y_p0;
            end
        end
    end

    assign OUT_VALID       = vld_p1;
    assign PU_O            = pu_p1;
    assign ANGLE_OR_PLANAR = mode_p1;

endmodule
